digit_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the four-digit seven-segment display on the Basys 3 scoreboard. It drives the 2-bit select of the digit/segment 4:1 multiplexers, so one digit value reaches the shared segment bus per slot. It also drives the matching active-low anode and inserts a blanking guard at every digit change to suppress ghosting. Disabled digits are skipped, so unused score positions never steal refresh time.

---
 rtl/digit_scan_ctrl_if.sv | 29 ++
 rtl/digit_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_scan_ctrl_if.sv
// Signal bundle between the digit scan controller and the display side.
// The host drives the scan enable and per-digit enables; the controller
// returns the mux select, the active-low anodes and the slot status.
interface digit_scan_ctrl_if;
    logic       en;
    logic [3:0] digit_en;
    logic [1:0] sel;
    logic [3:0] an;
    logic       blank;
    logic       slot_tick;

    modport master (
        output en,
        output digit_en,
        input  sel,
        input  an,
        input  blank,
        input  slot_tick
    );

    modport slave (
        input  en,
        input  digit_en,
        output sel,
        output an,
        output blank,
        output slot_tick
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed scan controller for a four-digit seven-segment display.
// Each digit owns a slot of REFRESH_DIV cycles; the first BLANK_CYCLES of a
// slot keep every anode off so the segment bus can settle on the new digit.
// Disabled digits are skipped when the next slot's digit is chosen.
// All outputs are registered and describe the same cycle as the slot counter.

// Property checker bound into the controller: anode safety invariants.
module digit_scan_ctrl_chk #(
    parameter int BLANK_CYCLES = 1000
) (
    input logic       clk,
    input logic       reset,
    input logic [1:0] sel,
    input logic [3:0] an,
    input logic       blank
);
    a_one_anode: assert property (@(posedge clk) disable iff (reset) $onehot0(~an));

    a_blank_flag: assert property (@(posedge clk) disable iff (reset) blank == (an == 4'b1111));

    generate
        if (BLANK_CYCLES > 0) begin : g_guard_chk
            a_dark_on_switch: assert property (@(posedge clk) disable iff (reset)
                (sel != $past(sel)) |-> (an == 4'b1111));
        end
    endgenerate
endmodule

module digit_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    digit_scan_ctrl_if.slave bus
);
    localparam int               CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    // Registered state and outputs
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic [3:0]       r_an;
    logic             r_blank;
    logic             r_tick;

    // Values for the cycle being entered at the next edge
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_sel_nxt;
    logic [3:0]       w_an_nxt;
    logic             w_blank_nxt;
    logic             w_tick_nxt;
    logic             w_in_blank;
    logic             w_wrap;

    // Round-robin search for the next enabled digit after cur; cur itself is
    // tried last, and with no digit enabled the select simply holds.
    function automatic logic [1:0] next_enabled(input logic [1:0] cur, input logic [3:0] mask);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = cur;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

    // Active-low anode pattern for one digit index.
    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        logic [3:0] a;
        case (idx)
            2'd0:    a = 4'b1110;
            2'd1:    a = 4'b1101;
            2'd2:    a = 4'b1011;
            2'd3:    a = 4'b0111;
            default: a = 4'b1111;
        endcase
        return a;
    endfunction

    // Slot counter and select: count while enabled, pick a new digit only at the wrap.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_sel_nxt = r_sel;
        w_wrap    = (r_cnt == CNT_LAST);
        if (!bus.en) begin
            w_cnt_nxt = CNT_ZERO;
            w_sel_nxt = r_sel;
        end else if (w_wrap) begin
            w_cnt_nxt = CNT_ZERO;
            w_sel_nxt = next_enabled(r_sel, bus.digit_en);
        end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
            w_sel_nxt = r_sel;
        end
    end

    // The guard window only exists when BLANK_CYCLES is non-zero.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_guard
            assign w_in_blank = 1'b0;
        end else begin : g_guard
            assign w_in_blank = (w_cnt_nxt < CNT_BLANK);
        end
    endgenerate

    // Output image for the next cycle: dark when disabled, in the guard window or on a disabled digit.
    always_comb begin
        w_an_nxt    = 4'b1111;
        w_blank_nxt = 1'b1;
        w_tick_nxt  = 1'b0;
        if (bus.en) begin
            w_tick_nxt = (w_cnt_nxt == CNT_LAST);
            if (!w_in_blank && bus.digit_en[w_sel_nxt]) begin
                w_an_nxt    = anode_for(w_sel_nxt);
                w_blank_nxt = 1'b0;
            end else begin
                w_an_nxt    = 4'b1111;
                w_blank_nxt = 1'b1;
            end
        end else begin
            w_an_nxt    = 4'b1111;
            w_blank_nxt = 1'b1;
            w_tick_nxt  = 1'b0;
        end
    end

    // State and output registers; reset forces the display dark at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= CNT_ZERO;
            r_sel   <= 2'd0;
            r_an    <= 4'b1111;
            r_blank <= 1'b1;
            r_tick  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_an    <= w_an_nxt;
            r_blank <= w_blank_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    assign bus.sel       = r_sel;
    assign bus.an        = r_an;
    assign bus.blank     = r_blank;
    assign bus.slot_tick = r_tick;

    digit_scan_ctrl_chk #(
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .sel   (r_sel),
        .an    (r_an),
        .blank (r_blank)
    );
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl with REFRESH_DIV = 8, BLANK_CYCLES = 2.
// Hand-computed vector table, corner-case sequences, then random stimulus
// against a slot-level reference model.
module tb_digit_scan_ctrl;
    localparam int RD = 8;
    localparam int BC = 2;

    logic clk = 1'b0;
    logic reset;

    digit_scan_ctrl_if u_if ();

    digit_scan_ctrl #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    // Free-running 100 MHz-style clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: position inside the slot, displayed digit,
    // and the enables that were in force for the visible cycle.
    int         m_cnt;
    int         m_sel;
    logic       m_en_q;
    logic [3:0] m_de_q;

    typedef struct {
        logic       en;
        logic [3:0] de;
        int         ncyc;
        logic [1:0] sel;
        logic [3:0] an;
        logic       blank;
        logic       tick;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic [3:0] de, input int ncyc,
                       input logic [1:0] sel, input logic [3:0] an, input logic blank, input logic tick);
        vec_t v;
        v.en = en; v.de = de; v.ncyc = ncyc;
        v.sel = sel; v.an = an; v.blank = blank; v.tick = tick;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] s, input logic [3:0] a,
                              input logic b, input logic t);
        check({tag, ".sel"},   {2'b00, u_if.sel},        {2'b00, s});
        check({tag, ".an"},    u_if.an,                  a);
        check({tag, ".blank"}, {3'b000, u_if.blank},     {3'b000, b});
        check({tag, ".tick"},  {3'b000, u_if.slot_tick}, {3'b000, t});
    endtask

    function automatic int next_digit(input int cur, input logic [3:0] de);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            idx = (cur + k) % 4;
            if (de[idx[1:0]]) return idx;
        end
        return cur;
    endfunction

    function automatic logic [3:0] model_an();
        if (!m_en_q || m_cnt < BC || !m_de_q[m_sel[1:0]]) return 4'b1111;
        return ~(4'b0001 << m_sel);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_sel = 0; m_en_q = 1'b0; m_de_q = 4'b0000;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
        end else if (!u_if.en) begin
            m_cnt = 0; m_en_q = 1'b0; m_de_q = u_if.digit_en;
        end else begin
            if (m_cnt == RD - 1) begin
                m_cnt = 0;
                m_sel = next_digit(m_sel, u_if.digit_en);
            end else begin
                m_cnt++;
            end
            m_en_q = 1'b1; m_de_q = u_if.digit_en;
        end
    endtask

    task automatic compare_model(input string tag);
        logic [3:0] a;
        a = model_an();
        check_outs(tag, m_sel[1:0], a, (a == 4'b1111), (m_en_q && m_cnt == RD - 1));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Bound on total run time
    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    // Main stimulus and checking sequence
    initial begin
        int ticks;
        reset = 1'b1;
        u_if.en = 1'b0;
        u_if.digit_en = 4'b0000;
        model_reset();

        // Vector table, starting from the just-released reset state
        add(1'b1, 4'b1111, 1, 2'd0, 4'b1111, 1'b1, 1'b0);
        add(1'b1, 4'b1111, 1, 2'd0, 4'b1110, 1'b0, 1'b0);
        add(1'b1, 4'b1111, 5, 2'd0, 4'b1110, 1'b0, 1'b1);
        add(1'b1, 4'b1111, 1, 2'd1, 4'b1111, 1'b1, 1'b0);
        add(1'b1, 4'b1111, 2, 2'd1, 4'b1101, 1'b0, 1'b0);
        add(1'b1, 4'b1111, 5, 2'd1, 4'b1101, 1'b0, 1'b1);
        add(1'b1, 4'b1111, 3, 2'd2, 4'b1011, 1'b0, 1'b0);
        add(1'b1, 4'b1111, 8, 2'd3, 4'b0111, 1'b0, 1'b0);
        add(1'b1, 4'b1111, 6, 2'd0, 4'b1111, 1'b1, 1'b0);
        add(1'b1, 4'b0101, 2, 2'd0, 4'b1110, 1'b0, 1'b0);
        add(1'b1, 4'b0101, 5, 2'd0, 4'b1110, 1'b0, 1'b1);
        add(1'b1, 4'b0101, 1, 2'd2, 4'b1111, 1'b1, 1'b0);
        add(1'b1, 4'b0101, 2, 2'd2, 4'b1011, 1'b0, 1'b0);
        add(1'b1, 4'b0101, 6, 2'd0, 4'b1111, 1'b1, 1'b0);
        add(1'b1, 4'b0101, 8, 2'd2, 4'b1111, 1'b1, 1'b0);
        add(1'b1, 4'b0101, 7, 2'd2, 4'b1011, 1'b0, 1'b1);
        add(1'b1, 4'b1000, 1, 2'd3, 4'b1111, 1'b1, 1'b0);
        add(1'b1, 4'b1000, 2, 2'd3, 4'b0111, 1'b0, 1'b0);
        add(1'b1, 4'b1000, 8, 2'd3, 4'b0111, 1'b0, 1'b0);
        add(1'b1, 4'b1000, 6, 2'd3, 4'b1111, 1'b1, 1'b0);
        add(1'b1, 4'b1000, 3, 2'd3, 4'b0111, 1'b0, 1'b0);
        add(1'b1, 4'b0000, 1, 2'd3, 4'b1111, 1'b1, 1'b0);
        add(1'b1, 4'b0000, 3, 2'd3, 4'b1111, 1'b1, 1'b1);
        add(1'b1, 4'b0000, 8, 2'd3, 4'b1111, 1'b1, 1'b1);

        // Reset state, before any edge and while held for 5 clocks
        #1;
        check_outs("reset_async", 2'd0, 4'b1111, 1'b1, 1'b0);
        repeat (5) begin
            cycle();
            check_outs("reset_hold", 2'd0, 4'b1111, 1'b1, 1'b0);
        end
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            u_if.en       = vecs[i].en;
            u_if.digit_en = vecs[i].de;
            repeat (vecs[i].ncyc) cycle();
            check_outs($sformatf("vec%0d", i), vecs[i].sel, vecs[i].an, vecs[i].blank, vecs[i].tick);
            compare_model($sformatf("vec%0d_model", i));
        end

        // No digit enabled for 32 cycles: dark, select frozen, ticks keep coming
        ticks = 0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            if (u_if.slot_tick) ticks++;
            check("dark.an", u_if.an, 4'b1111);
            check("dark.sel", {2'b00, u_if.sel}, 4'd3);
        end
        check("dark.ticks", ticks[3:0], 4'd4);

        // Scan disable at cnt 4 of the digit-1 slot, 3 cycles low, then resume
        u_if.digit_en = 4'b1111;
        repeat (13) cycle();
        check_outs("pre_drop", 2'd1, 4'b1101, 1'b0, 1'b0);
        u_if.en = 1'b0;
        cycle();
        check_outs("drop", 2'd1, 4'b1111, 1'b1, 1'b0);
        repeat (2) begin
            cycle();
            check_outs("drop_hold", 2'd1, 4'b1111, 1'b1, 1'b0);
        end
        u_if.en = 1'b1;
        cycle();
        check_outs("reen_cnt1", 2'd1, 4'b1111, 1'b1, 1'b0);
        cycle();
        check_outs("reen_cnt2", 2'd1, 4'b1101, 1'b0, 1'b0);
        repeat (5) cycle();
        check_outs("reen_cnt7", 2'd1, 4'b1101, 1'b0, 1'b1);
        cycle();
        check_outs("reen_adv", 2'd2, 4'b1111, 1'b1, 1'b0);

        // Asynchronous reset between edges at cnt 5 of the digit-2 slot
        repeat (5) cycle();
        check_outs("pre_rst", 2'd2, 4'b1011, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outs("mid_rst", 2'd0, 4'b1111, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_outs("rst_held", 2'd0, 4'b1111, 1'b1, 1'b0);
        reset = 1'b0;
        cycle();
        check_outs("rel_cnt1", 2'd0, 4'b1111, 1'b1, 1'b0);
        cycle();
        check_outs("rel_cnt2", 2'd0, 4'b1110, 1'b0, 1'b0);
        repeat (5) cycle();
        check_outs("rel_cnt7", 2'd0, 4'b1110, 1'b0, 1'b1);
        cycle();
        check_outs("rel_adv", 2'd1, 4'b1111, 1'b1, 1'b0);

        // Random enables, digit masks and occasional resets against the model
        for (int i = 0; i < 3000; i++) begin
            u_if.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) u_if.digit_en = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 199) == 0);
            cycle();
            compare_model("rand");
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
